// File: rtl/branch_resolve.sv
// Branch resolution: decodes taken/not-taken from comparator flags, issues a registered
// PC redirect and a timed IF/ID flush. Optional counters enabled by `BRANCH_STATS_EN.
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

module branch_resolve #(
  parameter int REG_WIDTH    = `REG_WIDTH,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  input  logic                 ex_is_branch,
  input  logic                 ex_is_jump,
  input  logic [2:0]           ex_funct3,
  input  logic [REG_WIDTH-1:0] ex_target,
  input  logic                 br_eq,
  input  logic                 br_lt,
  output logic                 br_un,
  output logic                 redirect_valid,
  output logic [REG_WIDTH-1:0] redirect_pc,
  output logic                 flush_if,
  output logic                 flush_id,
  output logic                 misalign_exc,
  output logic                 illegal_exc,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_taken
);

  typedef enum logic {IDLE, FLUSH} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t     state_q;
  logic [3:0] flush_cnt_q;

  logic cond_taken;
  logic funct3_illegal;
  logic accept;
  logic legal_branch;
  logic illegal_hit;
  logic taken;

  assign br_un = (ex_funct3 == 3'b110) || (ex_funct3 == 3'b111);

  always_comb begin
    cond_taken     = 1'b0;
    funct3_illegal = 1'b0;
    case (ex_funct3)
      3'b000:         cond_taken = br_eq;
      3'b001:         cond_taken = !br_eq;
      3'b100, 3'b110: cond_taken = br_lt;
      3'b101, 3'b111: cond_taken = !br_lt;
      default:        funct3_illegal = 1'b1;
    endcase
  end

  // Wrong-path instructions arriving during FLUSH are never accepted.
  assign accept       = (state_q == IDLE) && ex_valid;
  assign legal_branch = ex_is_branch && !ex_is_jump && !funct3_illegal;
  assign illegal_hit  = ex_is_branch && !ex_is_jump && funct3_illegal;
  assign taken        = ex_is_jump || (legal_branch && cond_taken);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      flush_cnt_q    <= 4'd0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_if       <= 1'b0;
      flush_id       <= 1'b0;
      misalign_exc   <= 1'b0;
      illegal_exc    <= 1'b0;
    end else begin
      redirect_valid <= 1'b0;
      misalign_exc   <= 1'b0;
      illegal_exc    <= 1'b0;
      case (state_q)
        IDLE: begin
          flush_if <= 1'b0;
          flush_id <= 1'b0;
          if (accept && taken) begin
            if (ex_target[1:0] == 2'b00) begin
              redirect_valid <= 1'b1;
              redirect_pc    <= ex_target;
              flush_if       <= 1'b1;
              flush_id       <= 1'b1;
              flush_cnt_q    <= CNT_LOAD;
              state_q        <= (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
            end else begin
              misalign_exc <= 1'b1;
            end
          end else if (accept && illegal_hit) begin
            illegal_exc <= 1'b1;
          end
        end
        FLUSH: begin
          if (flush_cnt_q == 4'd0) begin
            state_q  <= IDLE;
            flush_if <= 1'b0;
            flush_id <= 1'b0;
          end else begin
            flush_cnt_q <= flush_cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  // Misaligned taken branches still count: the outcome was resolved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches <= 32'd0;
      stat_taken    <= 32'd0;
    end else if (accept && legal_branch) begin
      stat_branches <= stat_branches + 32'd1;
      if (cond_taken) stat_taken <= stat_taken + 32'd1;
    end
  end
`else
  assign stat_branches = 32'd0;
  assign stat_taken    = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: per-cycle expected outputs are queued by a
// cycle model when stimulus is driven and compared one cycle later.
module tb_branch_resolve;

  localparam int RW = 32;
  localparam int FC = 2;
  localparam int EW = RW + 4;

  logic          clk;
  logic          rst_n;
  logic          ex_valid;
  logic          ex_is_branch;
  logic          ex_is_jump;
  logic [2:0]    ex_funct3;
  logic [RW-1:0] ex_target;
  logic          br_eq;
  logic          br_lt;
  logic          br_un;
  logic          redirect_valid;
  logic [RW-1:0] redirect_pc;
  logic          flush_if;
  logic          flush_id;
  logic          misalign_exc;
  logic          illegal_exc;
  logic [31:0]   stat_branches;
  logic [31:0]   stat_taken;

  branch_resolve #(.REG_WIDTH(RW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
    .ex_is_jump(ex_is_jump), .ex_funct3(ex_funct3), .ex_target(ex_target),
    .br_eq(br_eq), .br_lt(br_lt), .br_un(br_un), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush_if(flush_if), .flush_id(flush_id),
    .misalign_exc(misalign_exc), .illegal_exc(illegal_exc),
    .stat_branches(stat_branches), .stat_taken(stat_taken)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state: flush cycles remaining (including the current cycle), last redirect pc
  int            m_left;
  logic [RW-1:0] m_pc;
  int unsigned   m_br;
  int unsigned   m_tk;
  logic [EW-1:0] exp_q[$];

  // Driver: present one EX-stage slot, queue the expected next-cycle outputs, check them.
  task automatic drive_cycle(input string name, input logic v, input logic br, input logic jmp,
                             input logic [2:0] f3, input logic [RW-1:0] tgt,
                             input logic eq, input logic lt);
    logic          busy, tk, ill, e_rv, e_mis, e_ill, e_fl;
    logic [EW-1:0] e;
    int            nleft;
    ex_valid = v; ex_is_branch = br; ex_is_jump = jmp; ex_funct3 = f3;
    ex_target = tgt; br_eq = eq; br_lt = lt;
    #1;
    tests_run++;
    if (br_un !== (f3 == 3'd6 || f3 == 3'd7)) begin
      tests_failed++;
      $display("FAIL %s br_un: got %b expected %b", name, br_un, (f3 == 3'd6 || f3 == 3'd7));
    end
    busy  = (m_left > 0) && (FC > 1);
    nleft = (m_left > 0) ? m_left - 1 : 0;
    e_rv = 1'b0; e_mis = 1'b0; e_ill = 1'b0;
    tk = 1'b0; ill = 1'b0;
    if (jmp) tk = 1'b1;
    else if (br) begin
      case (f3)
        3'd0: tk = eq;
        3'd1: tk = ~eq;
        3'd4: tk = lt;
        3'd6: tk = lt;
        3'd5: tk = ~lt;
        3'd7: tk = ~lt;
        default: ill = 1'b1;
      endcase
    end
    if (!busy && v) begin
      if (tk) begin
        if (tgt[1:0] == 2'b00) begin
          e_rv = 1'b1; m_pc = tgt; nleft = FC;
        end else e_mis = 1'b1;
      end else if (ill) e_ill = 1'b1;
      if (br && !jmp && !ill) begin
        m_br++;
        if (tk) m_tk++;
      end
    end
    m_left = nleft;
    e_fl = (nleft > 0);
    exp_q.push_back({e_rv, m_pc, e_fl, e_mis, e_ill});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    tests_run += 5;
    if (redirect_valid !== e[EW-1]) begin
      tests_failed++;
      $display("FAIL %s redirect_valid: got %b expected %b", name, redirect_valid, e[EW-1]);
    end
    if (redirect_pc !== e[EW-2:3]) begin
      tests_failed++;
      $display("FAIL %s redirect_pc: got %h expected %h", name, redirect_pc, e[EW-2:3]);
    end
    if (flush_if !== e[2] || flush_id !== e[2]) begin
      tests_failed++;
      $display("FAIL %s flush: got if=%b id=%b expected %b", name, flush_if, flush_id, e[2]);
    end
    if (misalign_exc !== e[1]) begin
      tests_failed++;
      $display("FAIL %s misalign_exc: got %b expected %b", name, misalign_exc, e[1]);
    end
    if (illegal_exc !== e[0]) begin
      tests_failed++;
      $display("FAIL %s illegal_exc: got %b expected %b", name, illegal_exc, e[0]);
    end
  endtask

  task automatic idle_cycles(input string name, input int n);
    for (int i = 0; i < n; i++) drive_cycle(name, 1'b0, 1'b0, 1'b0, 3'd0, '0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    m_left = 0; m_pc = '0; m_br = 0; m_tk = 0;
    exp_q.delete();
  endtask

  task automatic check_stats(input string name);
    logic [31:0] eb, et;
`ifdef BRANCH_STATS_EN
    eb = m_br; et = m_tk;
`else
    eb = 32'd0; et = 32'd0;
`endif
    tests_run += 2;
    if (stat_branches !== eb) begin
      tests_failed++;
      $display("FAIL %s stat_branches: got %0d expected %0d", name, stat_branches, eb);
    end
    if (stat_taken !== et) begin
      tests_failed++;
      $display("FAIL %s stat_taken: got %0d expected %0d", name, stat_taken, et);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0;
    ex_funct3 = 3'd0; ex_target = '0; br_eq = 1'b0; br_lt = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({redirect_valid, flush_if, flush_id, misalign_exc, illegal_exc} !== 5'b0 ||
        redirect_pc !== '0) begin
      tests_failed++;
      $display("FAIL reset outputs: got rv=%b fi=%b fd=%b mis=%b ill=%b pc=%h expected all 0",
               redirect_valid, flush_if, flush_id, misalign_exc, illegal_exc, redirect_pc);
    end
    check_stats("reset");
    rst_n = 1'b1;
    idle_cycles("reset_idle", 2);
  endtask

  task automatic test_beq();
    drive_cycle("beq", 1'b1, 1'b1, 1'b0, 3'd0, 32'h100, 1'b1, 1'b0);
    idle_cycles("beq_flush", 3);
    check_stats("beq");
  endtask

  task automatic test_bltu();
    drive_cycle("bltu", 1'b1, 1'b1, 1'b0, 3'd6, 32'h200, 1'b0, 1'b0);
    idle_cycles("bltu_after", 1);
    check_stats("bltu");
  endtask

  task automatic test_jal_misalign();
    drive_cycle("jal_mis", 1'b1, 1'b0, 1'b1, 3'd0, 32'h102, 1'b0, 1'b0);
    idle_cycles("jal_mis_after", 1);
    // Jump wins over a simultaneous branch carrying an illegal funct3.
    drive_cycle("jump_wins", 1'b1, 1'b1, 1'b1, 3'd3, 32'h440, 1'b0, 1'b0);
    idle_cycles("jump_wins_after", 3);
    check_stats("jal");
  endtask

  task automatic test_back_to_back();
    drive_cycle("b2b_bne", 1'b1, 1'b1, 1'b0, 3'd1, 32'h200, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      drive_cycle("b2b_beq", 1'b1, 1'b1, 1'b0, 3'd0, 32'h300, 1'b1, 1'b0);
    idle_cycles("b2b_after", 3);
    check_stats("b2b");
  endtask

  task automatic test_illegal();
    drive_cycle("illegal", 1'b1, 1'b1, 1'b0, 3'd3, 32'h500, 1'b1, 1'b1);
    drive_cycle("illegal2", 1'b1, 1'b1, 1'b0, 3'd2, 32'h500, 1'b0, 1'b0);
    idle_cycles("illegal_after", 1);
    check_stats("illegal");
  endtask

  task automatic test_reset_mid_flush();
    drive_cycle("rst_flush_beq", 1'b1, 1'b1, 1'b0, 3'd0, 32'h600, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({redirect_valid, flush_if, flush_id} !== 3'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_flush: got rv=%b fi=%b fd=%b expected 000",
               redirect_valid, flush_if, flush_id);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_cycle("rst_flush_new", 1'b1, 1'b1, 1'b0, 3'd5, 32'h700, 1'b0, 1'b0);
    idle_cycles("rst_flush_after", 3);
    check_stats("rst_flush");
  endtask

  task automatic test_random();
    logic [2:0]    f3;
    logic [RW-1:0] tgt;
    for (int i = 0; i < 60; i++) begin
      f3  = 3'($urandom_range(0, 7));
      tgt = {RW{1'b0}} | {$urandom_range(0, 16'hffff), 2'($urandom_range(0, 3) == 0 ? 1 : 0)};
      drive_cycle("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 5) == 0), f3, tgt,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle_cycles("random_after", 3);
    check_stats("random");
  endtask

  initial begin
    test_reset();
    test_beq();
    test_bltu();
    test_jal_misalign();
    test_back_to_back();
    test_illegal();
    test_reset_mid_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
